// File: rtl/wire_cmd_serializer.sv
// wire_cmd_serializer
//   Watches the host Wire In word for a toggle-bit change and decodes each change
//   as one command. Commands with opcode 1..6 are sent as a 4-byte frame over a
//   valid/ready byte interface: header, arg high nibble, arg low byte, XOR checksum.
//   One further command can wait in a pending slot while a frame is in flight.
//
// Ports
//   clock      system clock (same domain as the Wire In endpoint)
//   resetn     asynchronous active-low reset
//   wire_data  [15] toggle, [14:12] opcode, [11:0] argument
//   tx_ready   UART transmitter can accept a byte
//   tx_data    byte to transmit
//   tx_valid   tx_data valid
//   busy       frame in progress
//   status     {err_overrun, err_opcode, busy, pending, 4'b0, cmd_count}
//
// state    | meaning
// ST_IDLE  | no frame in flight, tx_valid low
// ST_HDR   | presenting {HDR_TAG, opcode}
// ST_ARGH  | presenting {4'b0, arg[11:8]}
// ST_ARGL  | presenting arg[7:0]
// ST_CSUM  | presenting XOR of the three preceding bytes

module wire_cmd_serializer #(
    parameter logic [4:0] HDR_TAG   = 5'b10100,
    parameter int         CNT_WIDTH = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [15:0] wire_data,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic [15:0] status
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ARGH,
        ST_ARGL,
        ST_CSUM
    } state_t;

    state_t                 state, state_nxt;
    logic                   prev_toggle;
    logic [14:0]            act_word, act_word_nxt;
    logic [14:0]            pend_word, pend_word_nxt;
    logic                   pending, pending_nxt;
    logic [CNT_WIDTH-1:0]   cmd_count, cmd_count_nxt;
    logic                   err_overrun, err_overrun_nxt;
    logic                   err_opcode, err_opcode_nxt;

    logic                   new_cmd;
    logic                   xfer;
    logic                   can_start;
    logic                   start;
    logic [14:0]            start_word;
    logic [2:0]             start_op;

    logic [7:0]             hdr_byte, argh_byte, argl_byte, csum_byte;

    assign hdr_byte  = {HDR_TAG, act_word[14:12]};
    assign argh_byte = {4'b0000, act_word[11:8]};
    assign argl_byte = act_word[7:0];
    assign csum_byte = hdr_byte ^ argh_byte ^ argl_byte;

    assign tx_valid = (state != ST_IDLE);
    assign busy     = tx_valid;
    assign status   = {err_overrun, err_opcode, busy, pending, 4'b0000, 8'(cmd_count)};

    always_comb begin
        tx_data = 8'h00;
        case (state)
            ST_HDR:  tx_data = hdr_byte;
            ST_ARGH: tx_data = argh_byte;
            ST_ARGL: tx_data = argl_byte;
            ST_CSUM: tx_data = csum_byte;
            default: tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        act_word_nxt    = act_word;
        pend_word_nxt   = pend_word;
        pending_nxt     = pending;
        cmd_count_nxt   = cmd_count;
        err_overrun_nxt = err_overrun;
        err_opcode_nxt  = err_opcode;
        start           = 1'b0;
        start_word      = '0;
        start_op        = 3'd0;

        new_cmd   = wire_data[15] ^ prev_toggle;
        xfer      = tx_valid & tx_ready;
        // A new frame may begin when idle or on the edge the checksum byte leaves.
        can_start = (state == ST_IDLE) || ((state == ST_CSUM) && xfer);

        case (state)
            ST_HDR:  if (xfer) state_nxt = ST_ARGH;
            ST_ARGH: if (xfer) state_nxt = ST_ARGL;
            ST_ARGL: if (xfer) state_nxt = ST_CSUM;
            ST_CSUM: if (xfer) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        if (can_start && pending) begin
            // Pending word drains first; a word arriving on the same edge refills the slot.
            start         = 1'b1;
            start_word    = pend_word;
            pending_nxt   = new_cmd;
            if (new_cmd) begin
                pend_word_nxt = wire_data[14:0];
            end
        end else if (can_start && new_cmd) begin
            start      = 1'b1;
            start_word = wire_data[14:0];
        end else if (new_cmd) begin
            if (pending) begin
                err_overrun_nxt = 1'b1;
            end else begin
                pending_nxt   = 1'b1;
                pend_word_nxt = wire_data[14:0];
            end
        end

        if (start) begin
            start_op     = start_word[14:12];
            act_word_nxt = start_word;
            if (start_op == 3'd7) begin
                err_opcode_nxt = 1'b1;
                state_nxt      = ST_IDLE;
            end else begin
                cmd_count_nxt = cmd_count + CNT_WIDTH'(1);
                state_nxt     = (start_op == 3'd0) ? ST_IDLE : ST_HDR;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            prev_toggle <= 1'b0;
            act_word    <= '0;
            pend_word   <= '0;
            pending     <= 1'b0;
            cmd_count   <= '0;
            err_overrun <= 1'b0;
            err_opcode  <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev_toggle <= wire_data[15];
            act_word    <= act_word_nxt;
            pend_word   <= pend_word_nxt;
            pending     <= pending_nxt;
            cmd_count   <= cmd_count_nxt;
            err_overrun <= err_overrun_nxt;
            err_opcode  <= err_opcode_nxt;
        end
    end

endmodule
